// File: rtl/wb_port_arbiter_if.sv
// Signal bundle between the two requesting ports, the shared Wishbone slave and the arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface wb_port_arbiter_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  logic        dbg_req_i;
  logic        dbg_we_i;
  logic [31:0] dbg_adr_i;
  logic [31:0] dbg_dat_i;
  logic        dbg_ack_o;
  logic [31:0] dbg_dat_o;

  logic        s_cyc_o;
  logic        s_stb_o;
  logic        s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o;
  logic [31:0] s_dat_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;

  logic        timeout_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    input  dbg_req_i, dbg_we_i, dbg_adr_i, dbg_dat_i,
    output dbg_ack_o, dbg_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i,
    output timeout_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    output dbg_req_i, dbg_we_i, dbg_adr_i, dbg_dat_i,
    input  dbg_ack_o, dbg_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i,
    input  timeout_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Two-port arbiter (management Wishbone + debug port) onto one shared Wishbone slave,
// with alternating tie-break, master abort on port 0 and a per-transaction timeout.
module wb_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input logic              wb_clk_i,
  input logic              wb_rst_i,
  wb_port_arbiter_if.slave bus
);

  localparam logic [15:0] TCNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_RESP
  } state_t;

  state_t      r_state, w_state_nx;
  logic        r_owner, w_owner_nx;
  logic        r_last_owner, w_last_owner_nx;
  logic [31:0] r_rdata, w_rdata_nx;
  logic [15:0] r_tcnt, w_tcnt_nx;
  logic        r_timeout, w_timeout_nx;

  logic        w_req0;
  logic        w_req1;
  logic        w_grant;

  assign w_req0 = bus.wbs_cyc_i & bus.wbs_stb_i;
  assign w_req1 = bus.dbg_req_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_rdata      <= '0;
      r_tcnt       <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_owner      <= w_owner_nx;
      r_last_owner <= w_last_owner_nx;
      r_rdata      <= w_rdata_nx;
      r_tcnt       <= w_tcnt_nx;
      r_timeout    <= w_timeout_nx;
    end
  end

  always_comb begin
    w_state_nx      = r_state;
    w_owner_nx      = r_owner;
    w_last_owner_nx = r_last_owner;
    w_rdata_nx      = r_rdata;
    w_tcnt_nx       = r_tcnt;
    w_timeout_nx    = r_timeout;
    w_grant         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_req0 | w_req1) begin
          // On a tie the port that did not win last time gets the bus
          w_grant         = (w_req0 & w_req1) ? ~r_last_owner : w_req1;
          w_owner_nx      = w_grant;
          w_last_owner_nx = w_grant;
          w_tcnt_nx       = '0;
          w_state_nx      = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        // A port-0 abort wins over everything; a slave ack wins over the timeout
        if (!r_owner && !bus.wbs_cyc_i) begin
          w_state_nx = ST_IDLE;
        end else if (bus.s_ack_i) begin
          w_rdata_nx = bus.s_dat_i;
          w_state_nx = ST_RESP;
        end else if (r_tcnt == TCNT_LAST) begin
          w_rdata_nx   = ERR_DATA;
          w_timeout_nx = 1'b1;
          w_state_nx   = ST_RESP;
        end else begin
          w_tcnt_nx = r_tcnt + 16'd1;
        end
      end
      ST_RESP: begin
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  assign bus.s_cyc_o   = (r_state == ST_ACTIVE);
  assign bus.s_stb_o   = (r_state == ST_ACTIVE);
  assign bus.s_we_o    = r_owner ? bus.dbg_we_i  : bus.wbs_we_i;
  assign bus.s_sel_o   = r_owner ? 4'hF          : bus.wbs_sel_i;
  assign bus.s_adr_o   = r_owner ? bus.dbg_adr_i : bus.wbs_adr_i;
  assign bus.s_dat_o   = r_owner ? bus.dbg_dat_i : bus.wbs_dat_i;

  assign bus.wbs_ack_o = (r_state == ST_RESP) && !r_owner;
  assign bus.dbg_ack_o = (r_state == ST_RESP) &&  r_owner;
  assign bus.wbs_dat_o = r_rdata;
  assign bus.dbg_dat_o = r_rdata;
  assign bus.timeout_o = r_timeout;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against a transaction-level reference model.
module tb_wb_port_arbiter;

  localparam int          TMO = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(
    .TIMEOUT_CYCLES(TMO),
    .ERR_DATA      (ERR)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // Reference model: who holds the bus (-1 = nobody), how long it has held it,
  // which port is owed an acknowledge this cycle (-1 = none).
  int          m_owner   = -1;
  int          m_age     = 0;
  int          m_ackport = -1;
  int          m_last    = 1;
  logic [31:0] m_rdata   = '0;
  bit          m_to      = 1'b0;
  bit          m_valid   = 1'b0;
  bit          m_r0, m_r1;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_age = 0; m_ackport = -1; m_last = 1;
      m_rdata = '0; m_to = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_r0 = bus.wbs_cyc_i && bus.wbs_stb_i;
      m_r1 = bus.dbg_req_i;
      if (m_owner >= 0) begin
        if (m_owner == 0 && !bus.wbs_cyc_i) begin
          m_owner = -1;
        end else if (bus.s_ack_i) begin
          m_rdata = bus.s_dat_i; m_ackport = m_owner; m_owner = -1;
        end else if (m_age + 1 == TMO) begin
          m_rdata = ERR; m_to = 1'b1; m_ackport = m_owner; m_owner = -1;
        end else begin
          m_age++;
        end
      end else if (m_ackport >= 0) begin
        m_ackport = -1;
      end else if (m_r0 || m_r1) begin
        if (m_r0 && m_r1) m_owner = 1 - m_last;
        else              m_owner = m_r1 ? 1 : 0;
        m_last = m_owner;
        m_age  = 0;
      end
    end
  end

  logic [68:0] exp_fields;
  always @(negedge clk) begin
    if (m_valid) begin
      chk("ctrl", 128'({bus.s_cyc_o, bus.s_stb_o, bus.wbs_ack_o, bus.dbg_ack_o, bus.timeout_o}),
          128'({m_owner >= 0, m_owner >= 0, m_ackport == 0, m_ackport == 1, m_to}));
      chk("wbs_dat", 128'(bus.wbs_dat_o), 128'(m_rdata));
      chk("dbg_dat", 128'(bus.dbg_dat_o), 128'(m_rdata));
      if (m_owner >= 0) begin
        exp_fields = (m_owner == 1)
          ? {bus.dbg_we_i, 4'hF, bus.dbg_adr_i, bus.dbg_dat_i}
          : {bus.wbs_we_i, bus.wbs_sel_i, bus.wbs_adr_i, bus.wbs_dat_i};
        chk("fields", 128'({bus.s_we_o, bus.s_sel_o, bus.s_adr_o, bus.s_dat_o}), 128'(exp_fields));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;
    bus.dbg_req_i = 1'b0; bus.dbg_we_i = 1'b0;  bus.dbg_adr_i = '0; bus.dbg_dat_i = '0;
    bus.s_ack_i = 1'b0;   bus.s_dat_i = '0;
  endtask

  int  ncyc, ngr, steps;
  int  gr_owner[4];
  int  gr_step[4];
  bit  p0_on, p1_on, done;

  initial begin
    idle_inputs();
    rst = 1'b1;
    step(); step();
    chk("reset_state", 128'({bus.s_cyc_o, bus.wbs_ack_o, bus.dbg_ack_o, bus.timeout_o, bus.wbs_dat_o}), 128'(0));

    // Port-0 read, slave acks two cycles after the first strobe
    rst = 1'b0;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = 32'h3000_0004;
    step();
    chk("rd_strobe", 128'({bus.s_cyc_o, bus.s_adr_o}), 128'({1'b1, 32'h3000_0004}));
    step();
    step();
    bus.s_ack_i = 1'b1; bus.s_dat_i = 32'h1234_5678;
    step();
    chk("rd_ack", 128'({bus.wbs_ack_o, bus.dbg_ack_o, bus.wbs_dat_o}), 128'({2'b10, 32'h1234_5678}));
    chk("model_rdata_pin", 128'(m_rdata), 128'(32'h1234_5678));
    bus.s_ack_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    step();
    chk("rd_ack_single", 128'(bus.wbs_ack_o), 128'(0));

    // Simultaneous requests after reset alternate 0,1,0,1 with the slave acking at once
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_adr_i = 32'h100;
    bus.dbg_req_i = 1'b1; bus.dbg_adr_i = 32'h200;
    ngr = 0;
    for (int i = 0; i < 40 && ngr < 4; i++) begin
      step();
      if (bus.s_cyc_o) begin
        gr_owner[ngr] = (bus.s_adr_o == 32'h200) ? 1 : 0;
        gr_step[ngr]  = i;
        ngr++;
        bus.s_ack_i = 1'b1;
      end else begin
        bus.s_ack_i = 1'b0;
      end
    end
    chk("rr_grants", 128'(ngr), 128'(4));
    for (int i = 0; i < 4; i++) chk("rr_owner", 128'(gr_owner[i]), 128'(i % 2));
    for (int i = 1; i < 4; i++) chk("rr_gap", 128'(gr_step[i] - gr_step[i-1]), 128'(3));
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    step();
    bus.s_ack_i = 1'b0; bus.dbg_req_i = 1'b0;
    step(); step();

    // Port-1 write to a slave that never answers
    bus.dbg_req_i = 1'b1; bus.dbg_we_i = 1'b1; bus.dbg_adr_i = 32'h40; bus.dbg_dat_i = 32'hA5A5_A5A5;
    ncyc = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      if (bus.s_cyc_o) ncyc++;
      if (bus.dbg_ack_o) begin
        done = 1'b1;
        chk("to_dat", 128'(bus.dbg_dat_o), 128'(32'hDEAD_BEEF));
        chk("to_flag", 128'(bus.timeout_o), 128'(1));
      end
    end
    chk("to_done", 128'(done), 128'(1));
    chk("to_cyc_len", 128'(ncyc), 128'(4));
    bus.dbg_req_i = 1'b0;
    step(); step(); step();
    chk("to_sticky", 128'(bus.timeout_o), 128'(1));
    chk("model_to_pin", 128'(m_to), 128'(1));

    // Ack arriving on the very cycle the timeout would fire
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.dbg_req_i = 1'b1; bus.dbg_we_i = 1'b0; bus.dbg_adr_i = 32'h44;
    ncyc = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      if (bus.dbg_ack_o) begin
        done = 1'b1;
        chk("late_ack_dat", 128'(bus.dbg_dat_o), 128'(32'h0000_00FF));
        chk("late_ack_noto", 128'(bus.timeout_o), 128'(0));
      end
      if (bus.s_cyc_o) ncyc++;
      bus.s_ack_i = (bus.s_cyc_o && ncyc == TMO);
      bus.s_dat_i = 32'h0000_00FF;
    end
    chk("late_ack_done", 128'(done), 128'(1));
    chk("late_ack_len", 128'(ncyc), 128'(4));
    bus.s_ack_i = 1'b0; bus.dbg_req_i = 1'b0;
    step();

    // Port-0 abort hands the bus to a waiting port 1; reset then abandons that access
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_adr_i = 32'h50;
    bus.dbg_req_i = 1'b1; bus.dbg_adr_i = 32'h60;
    step();
    chk("abort_own0", 128'({bus.s_cyc_o, bus.s_adr_o}), 128'({1'b1, 32'h50}));
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    step();
    chk("abort_drop", 128'({bus.s_cyc_o, bus.wbs_ack_o, bus.dbg_ack_o}), 128'(0));
    step();
    chk("abort_own1", 128'({bus.s_cyc_o, bus.s_adr_o}), 128'({1'b1, 32'h60}));
    rst = 1'b1;
    step();
    chk("mid_reset", 128'({bus.s_cyc_o, bus.s_stb_o, bus.wbs_ack_o, bus.dbg_ack_o, bus.timeout_o, bus.dbg_dat_o}), 128'(0));
    rst = 1'b0; bus.dbg_req_i = 1'b0;
    step();

    // Randomized traffic
    p0_on = 1'b0; p1_on = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(399) == 0) begin
        rst = 1'b1; p0_on = 1'b0; p1_on = 1'b0;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.dbg_req_i = 1'b0;
      end else begin
        if (p0_on) begin
          if (bus.wbs_ack_o || $urandom_range(19) == 0) begin
            bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; p0_on = 1'b0;
          end
        end else if ($urandom_range(2) == 0) begin
          p0_on = 1'b1;
          bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
          bus.wbs_we_i  = 1'($urandom_range(1)); bus.wbs_sel_i = 4'($urandom_range(15));
          bus.wbs_adr_i = $urandom; bus.wbs_dat_i = $urandom;
        end
        if (p1_on) begin
          if (bus.dbg_ack_o) begin
            bus.dbg_req_i = 1'b0; p1_on = 1'b0;
          end
        end else if ($urandom_range(2) == 0) begin
          p1_on = 1'b1;
          bus.dbg_req_i = 1'b1; bus.dbg_we_i = 1'($urandom_range(1));
          bus.dbg_adr_i = $urandom; bus.dbg_dat_i = $urandom;
        end
      end
      bus.s_ack_i = ($urandom_range(3) == 0);
      bus.s_dat_i = $urandom;
    end

    idle_inputs();
    rst = 1'b0;
    repeat (5) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
